// File: rtl/ipm2t_hssthp_refclk_mon_pkg.sv
// Shared state encoding and width helper for the HSSTHP refclk monitor.
package ipm2t_hssthp_refclk_mon_pkg;

  localparam logic [1:0] ST_PD     = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_MEAS   = 2'd2;
  localparam logic [1:0] ST_OK     = 2'd3;

  // Width able to hold 0..win_cycles inclusive.
  function automatic int cw_width(input int win_cycles);
    return $clog2(win_cycles + 1);
  endfunction

endpackage

// File: rtl/ipm2t_hssthp_tgl_edge_sync_v1_0.sv
// Brings the refclk-domain divided toggle into the free clock domain and
// flags every level change (rise or fall) as a single-cycle edge.
module ipm2t_hssthp_tgl_edge_sync_v1_0 (
  input  logic clk,
  input  logic srst,
  input  logic tgl_async,
  output logic tgl_edge
);

  logic sync1_reg;
  logic sync2_reg;
  logic dly_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      dly_reg   <= 1'b0;
    end else begin
      sync1_reg <= tgl_async;
      sync2_reg <= sync1_reg;
      dly_reg   <= sync2_reg;
    end
  end

  assign tgl_edge = sync2_reg ^ dly_reg;

endmodule

// File: rtl/ipm2t_hssthp_refclk_monitor_v1_0.sv
// Fabric-side HSSTHP refclk buffer controller: sequences COM_POWERDOWN and
// qualifies the refclk by counting divided toggle edges over fixed windows.
module ipm2t_hssthp_refclk_monitor_v1_0
  import ipm2t_hssthp_refclk_mon_pkg::*;
#(
  parameter int PD_CYCLES     = 1024,
  parameter int SETTLE_CYCLES = 4096,
  parameter int WIN_CYCLES    = 16384,
  parameter int EXP_TGL       = 400,
  parameter int TOL           = 8,
  parameter int FAIL_LIMIT    = 3,
  localparam int CW           = cw_width(WIN_CYCLES)
) (
  input  logic          i_free_clk,
  input  logic          i_rst,
  input  logic          i_refclk_tgl,
  input  logic          i_pd_req,
  output logic          o_com_powerdown,
  output logic          o_refclk_ok,
  output logic          o_refclk_lost,
  output logic [CW-1:0] o_tgl_cnt,
  output logic [1:0]    o_state,
  output logic [7:0]    o_retry_cnt
);

  localparam int TMAX = (PD_CYCLES > SETTLE_CYCLES) ? PD_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(FAIL_LIMIT + 1);
  localparam int LO   = EXP_TGL - TOL;
  localparam int HI   = EXP_TGL + TOL;

  localparam logic [TW-1:0] PD_LAST     = TW'(PD_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WIN_CYCLES - 1);
  localparam logic [BW-1:0] BAD_LIMIT   = BW'(FAIL_LIMIT);

  logic [1:0]    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [CW-1:0] win_reg, win_next;
  logic [CW-1:0] edge_cnt_reg, edge_cnt_next;
  logic [BW-1:0] bad_reg, bad_next;
  logic [CW-1:0] tgl_cnt_reg, tgl_cnt_next;
  logic          ok_reg, ok_next;
  logic          lost_reg, lost_next;
  logic          pd_reg;
  logic [7:0]    retry_reg, retry_next;

  logic          tgl_edge;
  logic [CW-1:0] final_cnt;
  logic [BW-1:0] bad_inc;
  logic          win_last;
  logic          in_range;

  ipm2t_hssthp_tgl_edge_sync_v1_0 u_edge_sync (
    .clk       (i_free_clk),
    .srst      (i_rst),
    .tgl_async (i_refclk_tgl),
    .tgl_edge  (tgl_edge)
  );

  // Running count including this cycle's edge; this is the window result on the last cycle.
  always_comb begin
    final_cnt = (edge_cnt_reg == '1) ? edge_cnt_reg : edge_cnt_reg + CW'(tgl_edge);
    win_last  = (win_reg == WIN_LAST);
    in_range  = (int'(final_cnt) >= LO) && (int'(final_cnt) <= HI);
    bad_inc   = bad_reg + BW'(1);
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    win_next      = win_reg;
    edge_cnt_next = edge_cnt_reg;
    bad_next      = bad_reg;
    tgl_cnt_next  = tgl_cnt_reg;
    ok_next       = ok_reg;
    lost_next     = 1'b0;
    retry_next    = retry_reg;
    case (state_reg)
      ST_PD: begin
        ok_next       = 1'b0;
        win_next      = '0;
        edge_cnt_next = '0;
        if (i_pd_req) begin
          timer_next = '0;
        end else if (timer_reg == PD_LAST) begin
          state_next = ST_SETTLE;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      ST_SETTLE: begin
        win_next      = '0;
        edge_cnt_next = '0;
        if (i_pd_req) begin
          state_next = ST_PD;
          timer_next = '0;
          ok_next    = 1'b0;
          bad_next   = '0;
        end else if (timer_reg == SETTLE_LAST) begin
          state_next = ST_MEAS;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        if (i_pd_req) begin
          // User power-down discards the window silently.
          state_next    = ST_PD;
          timer_next    = '0;
          ok_next       = 1'b0;
          bad_next      = '0;
          win_next      = '0;
          edge_cnt_next = '0;
        end else if (!win_last) begin
          win_next      = win_reg + CW'(1);
          edge_cnt_next = final_cnt;
        end else begin
          win_next      = '0;
          edge_cnt_next = '0;
          tgl_cnt_next  = final_cnt;
          if (in_range) begin
            state_next = ST_OK;
            ok_next    = 1'b1;
            bad_next   = '0;
          end else if (state_reg == ST_OK) begin
            state_next = ST_MEAS;
            ok_next    = 1'b0;
            lost_next  = 1'b1;
            bad_next   = BW'(1);
          end else if (bad_inc >= BAD_LIMIT) begin
            state_next = ST_PD;
            timer_next = '0;
            bad_next   = '0;
            retry_next = (retry_reg == 8'hFF) ? retry_reg : retry_reg + 8'd1;
          end else begin
            bad_next = bad_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_free_clk) begin
    if (i_rst) begin
      state_reg    <= ST_PD;
      timer_reg    <= '0;
      win_reg      <= '0;
      edge_cnt_reg <= '0;
      bad_reg      <= '0;
      tgl_cnt_reg  <= '0;
      ok_reg       <= 1'b0;
      lost_reg     <= 1'b0;
      pd_reg       <= 1'b1;
      retry_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      win_reg      <= win_next;
      edge_cnt_reg <= edge_cnt_next;
      bad_reg      <= bad_next;
      tgl_cnt_reg  <= tgl_cnt_next;
      ok_reg       <= ok_next;
      lost_reg     <= lost_next;
      pd_reg       <= (state_next == ST_PD);
      retry_reg    <= retry_next;
    end
  end

  assign o_com_powerdown = pd_reg;
  assign o_refclk_ok     = ok_reg;
  assign o_refclk_lost   = lost_reg;
  assign o_tgl_cnt       = tgl_cnt_reg;
  assign o_state         = state_reg;
  assign o_retry_cnt     = retry_reg;

endmodule

// File: doc/ipm2t_hssthp_refclk_monitor_v1_0.md
Name: ipm2t_hssthp_refclk_monitor_v1_0

Overview:
- Fabric-side controller for the HSSTHP reference-clock differential buffer.
- Drives the buffer's COM_POWERDOWN through a timed power-up sequence.
- Measures the refclk-derived toggle returned to fabric against the free-running clock, flags refclk_ok/lost, and power-cycles the buffer after repeated bad measurements.
- Sits between the bufds wrapper and the transceiver reset sequencer. The sequencer gates PLL/lane reset release on o_refclk_ok.

Parameters:
- PD_CYCLES, 1024: minimum free-clk cycles COM_POWERDOWN is held high per power cycle.
- SETTLE_CYCLES, 4096: free-clk cycles after powerdown release before the first measurement.
- WIN_CYCLES, 16384: measurement window length in free-clk cycles.
- EXP_TGL, 400: expected toggle edges per window. Default assumes 100 MHz free clk, 156.25 MHz refclk, divide-by-64 toggle.
- TOL, 8: allowed deviation. Pass range is EXP_TGL-TOL to EXP_TGL+TOL, inclusive.
- FAIL_LIMIT, 3: consecutive bad windows before a power cycle.

Ports:
- i_free_clk  in  1  free-running fabric clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_refclk_tgl  in  1  asynchronous toggle from a divider in the refclk domain, outside this block.
- i_pd_req  in  1  user power-down request, level.
- o_com_powerdown  out  1  to bufds COM_POWERDOWN.
- o_refclk_ok  out  1  refclk present and in range.
- o_refclk_lost  out  1  one-cycle pulse on OK->bad transition.
- o_tgl_cnt  out  CW  edge count of the last completed window; CW = clog2(WIN_CYCLES+1).
- o_state  out  2  current state encoding.
- o_retry_cnt  out  8  power cycles caused by FAIL_LIMIT; saturates at 255.

Behaviour:
- Reset values: o_com_powerdown=1, o_refclk_ok=0, o_refclk_lost=0, o_tgl_cnt=0, o_retry_cnt=0, state=PD, all counters 0. Reset asserted in any state aborts immediately and returns to these values.
- Toggle input path: 2-FF synchroniser, then one delay register. edge = sync2 XOR dly. Each edge (rise or fall) counts as 1. Edge counter saturates at all-ones.
- State encoding: PD=0, SETTLE=1, MEAS=2, OK=3.
- PD:
  - o_com_powerdown=1, o_refclk_ok=0.
  - Timer is held at 0 while i_pd_req=1; otherwise it increments.
  - Exit to SETTLE when timer=PD_CYCLES-1 and i_pd_req=0.
- SETTLE:
  - o_com_powerdown=0.
  - Timer counts 0..SETTLE_CYCLES-1, then go to MEAS. Window counter and edge counter are cleared on entry.
- MEAS/OK window:
  - Window counter runs 0..WIN_CYCLES-1.
  - On the last cycle, the final count includes any edge in that cycle. o_tgl_cnt is loaded with it on the next cycle, and the counters restart with no gap between windows.
- MEAS evaluation at window end:
  - In range: go to OK; o_refclk_ok=1 from the following cycle; bad counter cleared.
  - Out of range: bad counter increments. If it reaches FAIL_LIMIT, go to PD, increment o_retry_cnt (saturating) and clear the bad counter. Otherwise stay in MEAS.
- OK evaluation at window end:
  - In range: stay in OK.
  - Out of range: o_refclk_ok falls and o_refclk_lost pulses high for exactly one cycle, both on the cycle after window end. Go to MEAS with bad counter=1.
- i_pd_req=1 in any non-PD state:
  - Next cycle: state=PD, o_com_powerdown=1, o_refclk_ok=0.
  - No lost pulse, no retry increment, window discarded, o_tgl_cnt unchanged.
- Simultaneous window end and i_pd_req: the request wins and the window is discarded.
- All outputs are registered.

Decomposition:
- Package ipm2t_hssthp_refclk_mon_pkg holds the state encoding constants (ST_PD, ST_SETTLE, ST_MEAS, ST_OK) and the CW width function.
- One sub-module, ipm2t_hssthp_tgl_edge_sync_v1_0: 2-FF synchroniser, delay register and edge pulse.
- The FSM and counters stay in the top module.

Test Plan:
- Bench params for all scenarios: PD_CYCLES=8, SETTLE_CYCLES=16, WIN_CYCLES=256, EXP_TGL=32, TOL=2, FAIL_LIMIT=3.
- Release reset, toggle every 8 cycles -> o_com_powerdown high 8 cycles then low; after 16+256 cycles o_refclk_ok=1, o_tgl_cnt=32, o_state=3.
- No toggles -> three windows with o_tgl_cnt=0, then o_state=0, o_com_powerdown=1, o_retry_cnt=1; sequence repeats.
- In OK, stop toggling -> at next window end o_refclk_lost is a 1-cycle pulse, o_refclk_ok=0, o_state=2; resume toggling -> OK after one window.
- Boundary counts: exactly 34 or 30 edges in a window -> pass; 35 or 29 -> bad. Toggle every 7 cycles (36/37 edges) -> bad.
- In OK, assert i_pd_req 5 cycles -> next cycle o_state=0, o_refclk_ok=0, no lost pulse; powerdown held 5+8 cycles; o_retry_cnt unchanged.
- Assert i_rst mid-MEAS and mid-OK -> next cycle all outputs at reset values, including o_retry_cnt=0 and o_tgl_cnt=0.
